// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte write delivery and read fetch.
// state      | meaning
// IDLE       | bus free, waiting for START
// ADDR       | shifting address + R/W bit
// ADDR_ACK   | holding address ACK low for one SCL high
// WRITE_BYTE | shifting a written data byte
// WRITE_ACK  | driving (or withholding) the data ACK
// READ_BYTE  | presenting a read byte bit by bit
// READ_ACK   | sampling the controller's ACK/NACK
// IGNORE     | not addressed, waiting for START or STOP
module i2c_target #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire logic             sda,
    input  logic                  scl,
    input  logic [ADDR_WIDTH-1:0] own_addr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_req,
    output logic                  addressed,
    output logic                  rw,
    output logic                  nack_sent
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE_BYTE, WRITE_ACK, READ_BYTE, READ_ACK, IGNORE
    } state_t;

    localparam logic [3:0] ADDR_BITS = 4'(ADDR_WIDTH + 1);
    localparam logic [3:0] DATA_BITS = 4'(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_hist, sda_hist;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    // Synchronizers reset to the idle-bus level so reset release does not fake an event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

    state_t                state, state_nxt;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [ADDR_WIDTH:0]   addr_shift, addr_shift_nxt;
    logic [DATA_WIDTH-2:0] data_shift, data_shift_nxt;
    logic [DATA_WIDTH-2:0] tx_shift, tx_shift_nxt;
    logic                  rx_ok, rx_ok_nxt;
    logic                  sda_low, sda_low_nxt;
    logic [DATA_WIDTH-1:0] rx_data_nxt;
    logic                  rx_valid_nxt, tx_req_nxt, addressed_nxt, rw_nxt, nack_sent_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            addr_shift <= '0;
            data_shift <= '0;
            tx_shift   <= '0;
            rx_ok      <= 1'b0;
            sda_low    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            addressed  <= 1'b0;
            rw         <= 1'b0;
            nack_sent  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            addr_shift <= addr_shift_nxt;
            data_shift <= data_shift_nxt;
            tx_shift   <= tx_shift_nxt;
            rx_ok      <= rx_ok_nxt;
            sda_low    <= sda_low_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            tx_req     <= tx_req_nxt;
            addressed  <= addressed_nxt;
            rw         <= rw_nxt;
            nack_sent  <= nack_sent_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        addr_shift_nxt = addr_shift;
        data_shift_nxt = data_shift;
        tx_shift_nxt   = tx_shift;
        rx_ok_nxt      = rx_ok;
        sda_low_nxt    = sda_low;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        tx_req_nxt     = 1'b0;
        addressed_nxt  = addressed;
        rw_nxt         = rw;
        nack_sent_nxt  = 1'b0;

        if (start_det) begin
            sda_low_nxt   = 1'b0;
            bit_cnt_nxt   = '0;
            addressed_nxt = 1'b0;
            state_nxt     = ADDR;
        end else if (stop_det) begin
            sda_low_nxt   = 1'b0;
            addressed_nxt = 1'b0;
            state_nxt     = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        addr_shift_nxt = {addr_shift[ADDR_WIDTH-1:0], sda_s};
                        bit_cnt_nxt    = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == ADDR_BITS) begin
                        bit_cnt_nxt = '0;
                        if (addr_shift[ADDR_WIDTH:1] == own_addr) begin
                            sda_low_nxt   = 1'b1;
                            rw_nxt        = addr_shift[0];
                            addressed_nxt = 1'b1;
                            tx_req_nxt    = addr_shift[0];
                            state_nxt     = ADDR_ACK;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            tx_shift_nxt = tx_data[DATA_WIDTH-2:0];
                            sda_low_nxt  = ~tx_data[DATA_WIDTH-1];
                            bit_cnt_nxt  = 4'd1;
                            state_nxt    = READ_BYTE;
                        end else begin
                            sda_low_nxt = 1'b0;
                            state_nxt   = WRITE_BYTE;
                        end
                    end
                end
                WRITE_BYTE: begin
                    if (scl_rise) begin
                        data_shift_nxt = {data_shift[DATA_WIDTH-3:0], sda_s};
                        bit_cnt_nxt    = bit_cnt + 4'd1;
                        if (bit_cnt == DATA_BITS - 4'd1) begin
                            rx_ok_nxt = rx_ready;
                            if (rx_ready) begin
                                rx_data_nxt  = {data_shift, sda_s};
                                rx_valid_nxt = 1'b1;
                            end else begin
                                nack_sent_nxt = 1'b1;
                            end
                        end
                    end else if (scl_fall && bit_cnt == DATA_BITS) begin
                        sda_low_nxt = rx_ok;
                        bit_cnt_nxt = '0;
                        state_nxt   = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                        state_nxt   = WRITE_BYTE;
                    end
                end
                READ_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == DATA_BITS) begin
                            sda_low_nxt = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = READ_ACK;
                        end else begin
                            sda_low_nxt  = ~tx_shift[DATA_WIDTH-2];
                            tx_shift_nxt = {tx_shift[DATA_WIDTH-3:0], 1'b0};
                            bit_cnt_nxt  = bit_cnt + 4'd1;
                        end
                    end
                end
                READ_ACK: begin
                    // bit_cnt marks that an ACK was seen and the next fall loads a new byte
                    if (scl_rise && bit_cnt == 4'd0) begin
                        if (!sda_s) begin
                            tx_req_nxt  = 1'b1;
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            addressed_nxt = 1'b0;
                            state_nxt     = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        tx_shift_nxt = tx_data[DATA_WIDTH-2:0];
                        sda_low_nxt  = ~tx_data[DATA_WIDTH-1];
                        state_nxt    = READ_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, table of write transfers, read/restart/reset sequences.
module tb_i2c_target;
    localparam int HB = 16;
    localparam int Q  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       ctl_low = 1'b0;
    logic       rx_ready = 1'b1;
    logic [6:0] own_addr = 7'h42;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addressed, rw, nack_sent;

    wire sda_bus;
    pullup (sda_bus);
    assign sda_bus = ctl_low ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    i2c_target dut (
        .clock(clock), .reset(reset), .sda(sda_bus), .scl(scl), .own_addr(own_addr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_req(tx_req), .addressed(addressed), .rw(rw), .nack_sent(nack_sent)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] rx_q[$];
    logic [7:0] bus_q[$];
    logic [7:0] tx_src[$];
    int rx_cnt = 0, nack_cnt = 0, txreq_cnt = 0, low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [7:0] d);
        if (bus_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: read %0h but no byte was served", name, d);
        end else begin
            check(name, {24'h0, d}, {24'h0, bus_q.pop_front()});
        end
    endtask

    // Scoreboard side: consumes expected rx bytes, serves read bytes on tx_req.
    always @(negedge clock) begin
        if (!ctl_low && sda_bus === 1'b0) low_cnt++;
        if (nack_sent) nack_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            if (rx_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rx_spurious: got rx_data=%0h, no byte expected", rx_data);
            end else begin
                check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
            end
        end
        if (tx_req) begin
            txreq_cnt++;
            if (tx_src.size() > 0) begin
                tx_data = tx_src.pop_front();
                bus_q.push_back(tx_data);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        ctl_low = 1'b0; scl = 1'b1; wait_clk(HB);
        ctl_low = 1'b1; wait_clk(HB);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_rstart();
        ctl_low = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(HB);
        ctl_low = 1'b1; wait_clk(HB);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        ctl_low = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(HB);
        ctl_low = 1'b0; wait_clk(HB);
    endtask

    task automatic send_bit(input logic b);
        ctl_low = !b; wait_clk(Q);
        scl = 1'b1; wait_clk(HB);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        ctl_low = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(HB / 2);
        b = sda_bus; wait_clk(HB / 2);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = !b;
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    typedef struct {
        logic [6:0] own;
        logic [6:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ready;
        logic       aack;
        logic       dack;
    } wr_vec_t;

    wr_vec_t vec[7];

    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] last_rx;
        logic [7:0] abyte;
        int c_rx, c_nk, c_low, c_tx;

        vec[0] = '{7'h42, 7'h42, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1};
        vec[1] = '{7'h42, 7'h43, 8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0};
        vec[2] = '{7'h42, 7'h42, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0};
        vec[3] = '{7'h01, 7'h01, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1};
        vec[4] = '{7'h7F, 7'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1};
        vec[5] = '{7'h7F, 7'h3F, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0};
        vec[6] = '{7'h2A, 7'h2A, 8'hC3, 8'h77, 1'b0, 1'b1, 1'b0};
        last_rx = 8'h00;

        wait_clk(4);
        check("rst_sda", {31'h0, sda_bus}, 32'h1);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_addressed", {31'h0, addressed}, 32'h0);
        check("rst_rw", {31'h0, rw}, 32'h0);
        check("rst_pulses", {29'h0, rx_valid, tx_req, nack_sent}, 32'h0);
        reset = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 7; i++) begin
            own_addr = vec[i].own;
            rx_ready = vec[i].ready;
            c_rx = rx_cnt; c_nk = nack_cnt; c_low = low_cnt;
            i2c_start();
            send_byte({vec[i].addr, 1'b0}, ack);
            check($sformatf("v%0d_addr_ack", i), {31'h0, ack}, {31'h0, vec[i].aack});
            check($sformatf("v%0d_addressed", i), {31'h0, addressed}, {31'h0, vec[i].aack});
            if (vec[i].aack) check($sformatf("v%0d_rw", i), {31'h0, rw}, 32'h0);
            if (vec[i].dack) rx_q.push_back(vec[i].d0);
            send_byte(vec[i].d0, ack);
            check($sformatf("v%0d_d0_ack", i), {31'h0, ack}, {31'h0, vec[i].dack});
            if (vec[i].dack) rx_q.push_back(vec[i].d1);
            send_byte(vec[i].d1, ack);
            check($sformatf("v%0d_d1_ack", i), {31'h0, ack}, {31'h0, vec[i].dack});
            i2c_stop();
            check($sformatf("v%0d_addr_after_stop", i), {31'h0, addressed}, 32'h0);
            check($sformatf("v%0d_rx_left", i), rx_q.size(), 32'h0);
            check($sformatf("v%0d_rx_pulses", i), rx_cnt - c_rx, vec[i].dack ? 2 : 0);
            check($sformatf("v%0d_nack_pulses", i), nack_cnt - c_nk,
                  (vec[i].aack && !vec[i].ready) ? 2 : 0);
            check($sformatf("v%0d_drove_sda", i), {31'h0, low_cnt != c_low}, {31'h0, vec[i].aack});
            if (vec[i].dack) last_rx = vec[i].d1;
            else check($sformatf("v%0d_rx_hold", i), {24'h0, rx_data}, {24'h0, last_rx});
        end

        // Read two bytes, ACK the first, NACK the second.
        own_addr = 7'h42; rx_ready = 1'b1;
        tx_src.push_back(8'h96); tx_src.push_back(8'h0F);
        c_tx = txreq_cnt;
        i2c_start();
        send_byte({7'h42, 1'b1}, ack);
        check("rd_addr_ack", {31'h0, ack}, 32'h1);
        check("rd_rw", {31'h0, rw}, 32'h1);
        recv_byte(d);
        check_bus("rd_byte0", d);
        send_bit(1'b0);
        recv_byte(d);
        check_bus("rd_byte1", d);
        send_bit(1'b1);
        check("rd_addressed_after_nack", {31'h0, addressed}, 32'h0);
        check("rd_sda_released", {31'h0, sda_bus}, 32'h1);
        check("rd_txreq_pulses", txreq_cnt - c_tx, 32'd2);
        i2c_stop();

        // Write interrupted after 3 bits by a repeated START into a read.
        tx_src.push_back(8'hC3);
        c_tx = txreq_cnt; c_rx = rx_cnt;
        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        check("rs_wr_ack", {31'h0, ack}, 32'h1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_rstart();
        send_byte({7'h42, 1'b1}, ack);
        check("rs_rd_ack", {31'h0, ack}, 32'h1);
        check("rs_rw", {31'h0, rw}, 32'h1);
        check("rs_addressed", {31'h0, addressed}, 32'h1);
        check("rs_txreq", txreq_cnt - c_tx, 32'd1);
        recv_byte(d);
        check_bus("rs_byte", d);
        send_bit(1'b1);
        i2c_stop();
        check("rs_no_rx", rx_cnt - c_rx, 32'd0);

        // Reset while the target holds the address ACK low.
        abyte = {7'h42, 1'b0};
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(abyte[i]);
        ctl_low = 1'b0;
        wait_clk(2);
        check("mid_ack_held", {31'h0, sda_bus}, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_sda", {31'h0, sda_bus}, 32'h1);
        check("mid_rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("mid_rst_addressed", {31'h0, addressed}, 32'h0);
        check("mid_rst_rw", {31'h0, rw}, 32'h0);
        check("mid_rst_pulses", {29'h0, rx_valid, tx_req, nack_sent}, 32'h0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(3);
        i2c_stop();

        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        check("post_rst_addr_ack", {31'h0, ack}, 32'h1);
        rx_q.push_back(8'h5E);
        send_byte(8'h5E, ack);
        check("post_rst_data_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        check("post_rst_rx_left", rx_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
